conv_window_sequencer: RTL

- Control FSM that drives one convolution data-process branch.
- On a `run` pulse it walks every output pixel, every input channel and every kernel tap, and issues data-memory and kernel-memory read addresses one tap per cycle.
- Issues MAC enable/first/last strobes aligned to the synchronous-read data, plus a result write strobe and address for each finished output pixel.
- Sits between the top-level layer scheduler (`run`/`done`) and the branch's memories and MAC/accumulator.

---
 rtl/conv_window_sequencer.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/conv_window_sequencer.sv
// Convolution tap sequencer: registered read addresses 1 cycle after issue, MAC strobes +1, result write +2.
// hold freezes tap issue only (bubbles flow down the pipe); CONV_SEQ_PERF_EN adds busy/hold cycle counters.
module conv_window_sequencer #(
  parameter int ADDR_WIDTH            = 10,
  parameter int CONV_PARTITION_WIDTH  = 3,
  parameter int CONV_PARTITION_HEIGHT = 3,
  parameter int CONV_LAYER_WIDTH      = 12,
  parameter int CONV_LAYER_HEIGHT     = 12,
  parameter int CHANNEL_NUM           = 2,
  parameter int CONV_RESULT_WIDTH     = 10,
  parameter int CONV_RESULT_HEIGHT    = 10
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  run,
  input  logic                  hold,
  output logic [ADDR_WIDTH-1:0] conv_data_addr,
  output logic [ADDR_WIDTH-1:0] conv_kernel_addr,
  output logic                  addr_valid,
  output logic                  mac_en,
  output logic                  mac_first,
  output logic                  mac_last,
  output logic                  result_we,
  output logic [ADDR_WIDTH-1:0] result_addr,
  output logic                  busy,
  output logic                  done
`ifdef CONV_SEQ_PERF_EN
  ,
  output logic [31:0]           perf_busy_cycles,
  output logic [31:0]           perf_hold_cycles
`endif
);

  localparam logic [15:0] KW_LAST = 16'(CONV_PARTITION_WIDTH - 1);
  localparam logic [15:0] KH_LAST = 16'(CONV_PARTITION_HEIGHT - 1);
  localparam logic [15:0] CH_LAST = 16'(CHANNEL_NUM - 1);
  localparam logic [15:0] RW_LAST = 16'(CONV_RESULT_WIDTH - 1);
  localparam logic [15:0] RH_LAST = 16'(CONV_RESULT_HEIGHT - 1);
  localparam logic [ADDR_WIDTH-1:0] ROW_STEP = ADDR_WIDTH'(CONV_LAYER_WIDTH);
  localparam logic [ADDR_WIDTH-1:0] CH_STEP  = ADDR_WIDTH'(CONV_LAYER_WIDTH * CONV_LAYER_HEIGHT);
  localparam logic [ADDR_WIDTH-1:0] A_ONE    = ADDR_WIDTH'(1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_t;

  state_t                state;
  logic [15:0]           kx, ky, ch, c, r;
  // Data address bases: current tap, kernel row start, channel start, pixel origin, output row origin.
  logic [ADDR_WIDTH-1:0] d_cur, d_row, d_ch, d_pix, d_line;
  logic [ADDR_WIDTH-1:0] k_cur, pix_cur;
  logic                  iss_first, iss_last;
  logic [ADDR_WIDTH-1:0] iss_pix, mac_pix;

  logic                  issue, last_kx, last_ky, last_ch, last_c, last_r, tap_first, pix_end;
  logic [ADDR_WIDTH-1:0] row_next, ch_next, pix_next;

  assign issue     = (state == S_ISSUE) && !hold;
  assign last_kx   = (kx == KW_LAST);
  assign last_ky   = (ky == KH_LAST);
  assign last_ch   = (ch == CH_LAST);
  assign last_c    = (c == RW_LAST);
  assign last_r    = (r == RH_LAST);
  assign tap_first = (kx == 16'd0) && (ky == 16'd0) && (ch == 16'd0);
  assign pix_end   = last_kx && last_ky && last_ch;
  assign row_next  = d_row + ROW_STEP;
  assign ch_next   = d_ch + CH_STEP;
  assign pix_next  = last_c ? (d_line + ROW_STEP) : (d_pix + A_ONE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state            <= S_IDLE;
      {kx, ky, ch, c, r} <= '0;
      {d_cur, d_row, d_ch, d_pix, d_line} <= '0;
      k_cur            <= '0;
      pix_cur          <= '0;
      iss_first        <= 1'b0;
      iss_last         <= 1'b0;
      iss_pix          <= '0;
      mac_pix          <= '0;
      conv_data_addr   <= '0;
      conv_kernel_addr <= '0;
      addr_valid       <= 1'b0;
      mac_en           <= 1'b0;
      mac_first        <= 1'b0;
      mac_last         <= 1'b0;
      result_we        <= 1'b0;
      result_addr      <= '0;
      busy             <= 1'b0;
      done             <= 1'b0;
    end else begin
      addr_valid <= issue;
      mac_en     <= addr_valid;
      mac_first  <= addr_valid & iss_first;
      mac_last   <= addr_valid & iss_last;
      mac_pix    <= iss_pix;
      result_we  <= mac_en & mac_last;
      if (mac_en && mac_last) result_addr <= mac_pix;
      done <= 1'b0;

      case (state)
        S_IDLE: if (run) begin
          state   <= S_ISSUE;
          {kx, ky, ch, c, r} <= '0;
          {d_cur, d_row, d_ch, d_pix, d_line} <= '0;
          k_cur   <= '0;
          pix_cur <= '0;
        end
        S_ISSUE: begin
          busy <= 1'b1;
          if (!hold) begin
            conv_data_addr   <= d_cur;
            conv_kernel_addr <= k_cur;
            iss_first        <= tap_first;
            iss_last         <= pix_end;
            iss_pix          <= pix_cur;
            if (!last_kx) begin
              kx    <= kx + 16'd1;
              d_cur <= d_cur + A_ONE;
              k_cur <= k_cur + A_ONE;
            end else if (!last_ky) begin
              kx    <= '0;
              ky    <= ky + 16'd1;
              d_row <= row_next;
              d_cur <= row_next;
              k_cur <= k_cur + A_ONE;
            end else if (!last_ch) begin
              kx    <= '0;
              ky    <= '0;
              ch    <= ch + 16'd1;
              d_ch  <= ch_next;
              d_row <= ch_next;
              d_cur <= ch_next;
              k_cur <= k_cur + A_ONE;
            end else begin
              // Pixel complete: step to the next output pixel's window origin.
              {kx, ky, ch} <= '0;
              k_cur   <= '0;
              pix_cur <= pix_cur + A_ONE;
              d_pix   <= pix_next;
              d_ch    <= pix_next;
              d_row   <= pix_next;
              d_cur   <= pix_next;
              if (last_c) begin
                c      <= '0;
                r      <= r + 16'd1;
                d_line <= d_line + ROW_STEP;
                if (last_r) state <= S_DRAIN;
              end else begin
                c <= c + 16'd1;
              end
            end
          end
        end
        S_DRAIN: if (result_we && !mac_en && !addr_valid) begin
          state <= S_DONE;
          done  <= 1'b1;
        end
        S_DONE: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

`ifdef CONV_SEQ_PERF_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      perf_busy_cycles <= '0;
      perf_hold_cycles <= '0;
    end else if (state == S_IDLE && run) begin
      perf_busy_cycles <= '0;
      perf_hold_cycles <= '0;
    end else begin
      if (busy) perf_busy_cycles <= perf_busy_cycles + 32'd1;
      if (state == S_ISSUE && hold) perf_hold_cycles <= perf_hold_cycles + 32'd1;
    end
  end
`endif

endmodule
